// File: rtl/id_ctrl_pkg.sv
// Shared types and constants for the registered RV32I control decoder (id_ctrl_pipe).
// Optional M-extension decode is enabled with the RV32M_EN macro.
package id_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_SHAMT = 3'd3,
    IMM_J     = 3'd4,
    IMM_U     = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

  // alu_ctrl is carried at its widest encoding; the top narrows it to ALUC_W.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       jump;
    logic       branch;
    logic       wen_rf;
    logic       alu_src;
    logic       en_dmem;
    logic       load_store;
    imm_sel_e   imm_sel;
    logic [4:0] alu_ctrl;
    logic [2:0] funct3;
    wb_sel_e    writeback;
    logic       bubble;
    logic       illegal;
  } ctrl_bundle_t;

  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational RV32I instruction -> control bundle decoder, plus register-use flags.
// RV32M_EN adds decode of the M-extension OP encodings.
module id_ctrl_decode
  import id_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         use_rs1,
  output logic         use_rs2,
  output logic         is_load
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ctrl     = '0;
    ctrl.rd  = instr[11:7];
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    is_load  = 1'b0;
    ill      = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.wen_rf  = 1'b1;
        ctrl.imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.wen_rf  = 1'b1;
        ctrl.imm_sel = IMM_U;
        ctrl.alu_src = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.wen_rf    = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.writeback = WB_PC4;
      end
      OP_JALR: begin
        ctrl.jump      = 1'b1;
        ctrl.wen_rf    = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.writeback = WB_PC4;
        use_rs1        = 1'b1;
      end
      OP_BRANCH: begin
        ill           = (f3[2:1] == 2'b01);
        ctrl.branch   = 1'b1;
        ctrl.imm_sel  = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.rd       = 5'd0;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.wen_rf    = 1'b1;
        ctrl.en_dmem   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.writeback = WB_MEM;
        ctrl.funct3    = f3;
        use_rs1        = 1'b1;
        is_load        = 1'b1;
      end
      OP_STORE: begin
        ctrl.en_dmem    = 1'b1;
        ctrl.load_store = 1'b1;
        ctrl.imm_sel    = IMM_S;
        ctrl.alu_src    = 1'b1;
        ctrl.funct3     = f3;
        ctrl.rd         = 5'd0;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OP_IMM: begin
        ctrl.wen_rf  = 1'b1;
        ctrl.alu_src = 1'b1;
        use_rs1      = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shifts: only funct7[5] (arith right) may be set, and never for slli.
          ctrl.imm_sel  = IMM_SHAMT;
          ctrl.alu_ctrl = alu_from_funct3(f3, f7[5]);
          ill = ({f7[6], f7[4:0]} != 6'd0) || (f3 == 3'b001 && f7[5]);
        end else begin
          ctrl.alu_ctrl = alu_from_funct3(f3, 1'b0);
        end
      end
      OP_REG: begin
        ctrl.wen_rf = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        if (f7 == 7'b0000000) begin
          ctrl.alu_ctrl = alu_from_funct3(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          ctrl.alu_ctrl = alu_from_funct3(f3, 1'b1);
          ill = (f3 != 3'b000) && (f3 != 3'b101);
        end
`ifdef RV32M_EN
        else if (f7 == 7'b0000001) begin
          ctrl.alu_ctrl = ALU_MUL + {2'b00, f3};
        end
`endif
        else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      ctrl         = '0;
      ctrl.rd      = instr[11:7];
      ctrl.rs1     = instr[19:15];
      ctrl.rs2     = instr[24:20];
      ctrl.illegal = 1'b1;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
      is_load      = 1'b0;
    end
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID->EX control stage: decode, 2-entry elastic buffer, load-use bubbles and flush.
// Define RV32M_EN to decode the M extension (requires ALUC_W >= 5).
module id_ctrl_pipe
  import id_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ALUC_W       = 5,
  parameter int HAZARD_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic              out_jump,
  output logic              out_branch,
  output logic              out_wen_rf,
  output logic              out_alu_src,
  output logic              out_en_dmem,
  output logic              out_load_store,
  output logic [2:0]        out_imm_sel,
  output logic [ALUC_W-1:0] out_alu_ctrl,
  output logic [2:0]        out_funct3,
  output logic [1:0]        out_writeback,
  output logic              out_bubble,
  output logic              out_illegal
);

  if (ALUC_W < 4) begin : g_aluc_w_too_small
    $error("id_ctrl_pipe: ALUC_W must be at least 4");
  end
`ifdef RV32M_EN
  if (ALUC_W < 5) begin : g_aluc_w_too_small_m
    $error("id_ctrl_pipe: RV32M_EN needs ALUC_W of at least 5");
  end
`endif

  ctrl_bundle_t    ctrl_p0, push_ctrl_p0, head_p1;
  logic [XLEN-1:0] push_pc_p0;
  logic            use_rs1_p0, use_rs2_p0, is_load_p0;
  logic            hazard_p0, accept_p0, push_p0, pop_p1;

  fifo_state_e     state_q, state_d;
  ctrl_bundle_t    slot0_p1, slot1_p1, pend_ctrl_p0;
  logic [XLEN-1:0] pc0_p1, pc1_p1, pend_pc_p0;
  logic            pend_vld_p0, trk_vld_p0;
  logic [4:0]      trk_rd_p0;
  logic            vld_p1;

  id_ctrl_decode u_decode (
    .instr   (in_instr),
    .ctrl    (ctrl_p0),
    .use_rs1 (use_rs1_p0),
    .use_rs2 (use_rs2_p0),
    .is_load (is_load_p0)
  );

  // ---- Stage p0: handshake, hazard detect, push selection ----
  assign vld_p1    = (state_q != FIFO_EMPTY);
  assign in_ready  = (state_q != FIFO_TWO) && !pend_vld_p0;
  assign accept_p0 = in_valid && in_ready && !flush;
  assign pop_p1    = vld_p1 && out_ready;
  assign hazard_p0 = (HAZARD_CHECK != 0) && trk_vld_p0 &&
                     ((use_rs1_p0 && ctrl_p0.rs1 == trk_rd_p0) ||
                      (use_rs2_p0 && ctrl_p0.rs2 == trk_rd_p0));
  assign push_p0   = !flush && (pend_vld_p0 ? (state_q != FIFO_TWO) : accept_p0);

  always_comb begin
    push_ctrl_p0 = ctrl_p0;
    push_pc_p0   = in_pc;
    if (pend_vld_p0) begin
      push_ctrl_p0 = pend_ctrl_p0;
      push_pc_p0   = pend_pc_p0;
    end else if (hazard_p0) begin
      push_ctrl_p0        = '0;
      push_ctrl_p0.bubble = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FIFO_EMPTY;
    end else begin
      case (state_q)
        FIFO_EMPTY: if (push_p0) state_d = FIFO_ONE;
        FIFO_ONE: begin
          if (push_p0 && !pop_p1)      state_d = FIFO_TWO;
          else if (!push_p0 && pop_p1) state_d = FIFO_EMPTY;
        end
        FIFO_TWO:   if (pop_p1) state_d = FIFO_ONE;
        default:    state_d = FIFO_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FIFO_EMPTY;
      pend_vld_p0 <= 1'b0;
      trk_vld_p0  <= 1'b0;
      trk_rd_p0   <= 5'd0;
    end else if (flush) begin
      state_q     <= FIFO_EMPTY;
      pend_vld_p0 <= 1'b0;
      trk_vld_p0  <= 1'b0;
      trk_rd_p0   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept_p0 && hazard_p0) pend_vld_p0 <= 1'b1;
      else if (pend_vld_p0 && state_q != FIFO_TWO) pend_vld_p0 <= 1'b0;
      if (accept_p0) begin
        trk_vld_p0 <= is_load_p0 && (ctrl_p0.rd != 5'd0);
        trk_rd_p0  <= ctrl_p0.rd;
      end
    end
  end

  // ---- Stage p1: buffer storage (slot0 is the head) ----
  always_ff @(posedge clk) begin
    if (push_p0 && (state_q == FIFO_EMPTY || (state_q == FIFO_ONE && pop_p1))) begin
      slot0_p1 <= push_ctrl_p0;
      pc0_p1   <= push_pc_p0;
    end else if (pop_p1 && state_q == FIFO_TWO) begin
      slot0_p1 <= slot1_p1;
      pc0_p1   <= pc1_p1;
    end
    if (push_p0 && state_q == FIFO_ONE && !pop_p1) begin
      slot1_p1 <= push_ctrl_p0;
      pc1_p1   <= push_pc_p0;
    end
    if (accept_p0 && hazard_p0) begin
      pend_ctrl_p0 <= ctrl_p0;
      pend_pc_p0   <= in_pc;
    end
  end

  // Data registers are not reset, so the outputs are masked while the buffer is empty.
  assign head_p1        = vld_p1 ? slot0_p1 : '0;
  assign out_valid      = vld_p1;
  assign out_pc         = vld_p1 ? pc0_p1 : '0;
  assign out_rd         = head_p1.rd;
  assign out_rs1        = head_p1.rs1;
  assign out_rs2        = head_p1.rs2;
  assign out_jump       = head_p1.jump;
  assign out_branch     = head_p1.branch;
  assign out_wen_rf     = head_p1.wen_rf;
  assign out_alu_src    = head_p1.alu_src;
  assign out_en_dmem    = head_p1.en_dmem;
  assign out_load_store = head_p1.load_store;
  assign out_imm_sel    = head_p1.imm_sel;
  assign out_alu_ctrl   = ALUC_W'(head_p1.alu_ctrl);
  assign out_funct3     = head_p1.funct3;
  assign out_writeback  = head_p1.writeback;
  assign out_bubble     = head_p1.bubble;
  assign out_illegal    = head_p1.illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Self-checking bench for id_ctrl_pipe: decode vector table plus handshake,
// load-use, backpressure, flush and reset sequences, with an expected-beat queue.
module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_ctrl;
  logic        out_jump, out_branch, out_wen_rf, out_alu_src, out_en_dmem, out_load_store;
  logic [2:0]  out_imm_sel, out_funct3;
  logic [1:0]  out_writeback;
  logic        out_bubble, out_illegal;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.XLEN(32), .ALUC_W(5), .HAZARD_CHECK(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_jump(out_jump), .out_branch(out_branch), .out_wen_rf(out_wen_rf),
    .out_alu_src(out_alu_src), .out_en_dmem(out_en_dmem), .out_load_store(out_load_store),
    .out_imm_sel(out_imm_sel), .out_alu_ctrl(out_alu_ctrl), .out_funct3(out_funct3),
    .out_writeback(out_writeback), .out_bubble(out_bubble), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        jump, branch, wen, alu_src, en_dmem, load_store;
    logic [2:0]  imm_sel;
    logic [4:0]  alu;
    logic [2:0]  funct3;
    logic [1:0]  wb;
    logic        bubble, illegal;
  } beat_t;

  typedef struct {
    logic [31:0] instr;
    beat_t       exp;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[14];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    ready_lo = 0;

  // fl = {jump, branch, wen, alu_src, en_dmem, load_store}
  function automatic beat_t e(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [5:0] fl, input logic [2:0] imm, input logic [4:0] alu,
                              input logic [2:0] f3, input logic [1:0] wb, input logic ill);
    beat_t b;
    b = '0;
    b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    {b.jump, b.branch, b.wen, b.alu_src, b.en_dmem, b.load_store} = fl;
    b.imm_sel = imm; b.alu = alu; b.funct3 = f3; b.wb = wb; b.illegal = ill;
    return b;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.pc = out_pc; b.rd = out_rd; b.rs1 = out_rs1; b.rs2 = out_rs2;
    b.jump = out_jump; b.branch = out_branch; b.wen = out_wen_rf; b.alu_src = out_alu_src;
    b.en_dmem = out_en_dmem; b.load_store = out_load_store; b.imm_sel = out_imm_sel;
    b.alu = out_alu_ctrl; b.funct3 = out_funct3; b.wb = out_writeback;
    b.bubble = out_bubble; b.illegal = out_illegal;
    return b;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_beat(input string name, input beat_t got, input beat_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic push_exp(input beat_t b, input logic [31:0] pc);
    beat_t t;
    t = b;
    t.pc = pc;
    exp_q.push_back(t);
  endtask

  task automatic mon_pop();
    beat_t w;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_beat: got %h, expected no beat", cur_beat());
    end else begin
      w = exp_q.pop_front();
      check_beat("beat", cur_beat(), w);
    end
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic cyc(output logic acc);
    @(negedge clk);
    acc = in_valid && in_ready && !flush;
    if (!in_ready) ready_lo++;
    if (out_valid && out_ready) mon_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    while (!acc && n < 50) begin
      cyc(acc);
      n++;
    end
    in_valid = 1'b0;
    check_bit("send_accepted", acc, 1'b1);
  endtask

  task automatic drain(input int n);
    logic acc;
    repeat (n) cyc(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t head, bub, e_add;
    logic  acc;

    tbl[0]  = '{32'h00228333, e(5'd6, 5'd5, 5'd2, 6'b001000, 3'd0, 5'd0, 3'd0, 2'd0, 1'b0)};
    tbl[1]  = '{32'h40000033, e(5'd0, 5'd0, 5'd0, 6'b001000, 3'd0, 5'd1, 3'd0, 2'd0, 1'b0)};
`ifdef RV32M_EN
    tbl[2]  = '{32'h022081B3, e(5'd3, 5'd1, 5'd2, 6'b001000, 3'd0, 5'd10, 3'd0, 2'd0, 1'b0)};
`else
    tbl[2]  = '{32'h022081B3, e(5'd3, 5'd1, 5'd2, 6'b000000, 3'd0, 5'd0, 3'd0, 2'd0, 1'b1)};
`endif
    tbl[3]  = '{32'hFFFFFFFF, e(5'd31, 5'd31, 5'd31, 6'b000000, 3'd0, 5'd0, 3'd0, 2'd0, 1'b1)};
    tbl[4]  = '{32'h0020A223, e(5'd0, 5'd1, 5'd2, 6'b000111, 3'd1, 5'd0, 3'd2, 2'd0, 1'b0)};
    tbl[5]  = '{32'h00208463, e(5'd0, 5'd1, 5'd2, 6'b010000, 3'd2, 5'd1, 3'd0, 2'd0, 1'b0)};
    tbl[6]  = '{32'h0020A463, e(5'd8, 5'd1, 5'd2, 6'b000000, 3'd0, 5'd0, 3'd0, 2'd0, 1'b1)};
    tbl[7]  = '{32'h123453B7, e(5'd7, 5'd8, 5'd3, 6'b001000, 3'd5, 5'd0, 3'd0, 2'd0, 1'b0)};
    tbl[8]  = '{32'h00000217, e(5'd4, 5'd0, 5'd0, 6'b001100, 3'd5, 5'd0, 3'd0, 2'd0, 1'b0)};
    tbl[9]  = '{32'h000280E7, e(5'd1, 5'd5, 5'd0, 6'b101100, 3'd0, 5'd0, 3'd0, 2'd2, 1'b0)};
    tbl[10] = '{32'h4040D193, e(5'd3, 5'd1, 5'd4, 6'b001100, 3'd3, 5'd7, 3'd0, 2'd0, 1'b0)};
    tbl[11] = '{32'hFFF0C193, e(5'd3, 5'd1, 5'd31, 6'b001100, 3'd0, 5'd5, 3'd0, 2'd0, 1'b0)};
    tbl[12] = '{32'h0000A283, e(5'd5, 5'd1, 5'd0, 6'b001110, 3'd0, 5'd0, 3'd2, 2'd1, 1'b0)};
    tbl[13] = '{32'h008000EF, e(5'd1, 5'd0, 5'd8, 6'b101000, 3'd4, 5'd0, 3'd0, 2'd2, 1'b0)};

    e_add = tbl[0].exp;
    bub = '0;
    bub.bubble = 1'b1;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_beat("rst_bundle_zero", cur_beat(), '0);
    @(posedge clk); #1;

    // Single add, one-cycle latency
    push_exp(e_add, 32'h40);
    send(32'h00228333, 32'h40);
    cyc(acc);
    check_int("add_latency", exp_q.size(), 0);

    // Decode table
    for (int i = 0; i < 14; i++) begin
      push_exp(tbl[i].exp, 32'h1000 + 32'(4 * i));
      send(tbl[i].instr, 32'h1000 + 32'(4 * i));
    end
    drain(4);
    check_int("table_drained", exp_q.size(), 0);

    // Load-use bubble
    ready_lo = 0;
    push_exp(tbl[12].exp, 32'h100);
    push_exp(bub, 32'h104);
    push_exp(e_add, 32'h104);
    send(32'h0000A283, 32'h100);
    send(32'h00228333, 32'h104);
    drain(5);
    check_int("hazard_ready_low_cycles", ready_lo, 1);
    check_int("hazard_drained", exp_q.size(), 0);

    // Backpressure with three instructions offered
    out_ready = 1'b0;
    push_exp(e(5'd1, 5'd0, 5'd1, 6'b001100, 3'd0, 5'd0, 3'd0, 2'd0, 1'b0), 32'h200);
    push_exp(e(5'd2, 5'd0, 5'd2, 6'b001100, 3'd0, 5'd0, 3'd0, 2'd0, 1'b0), 32'h204);
    push_exp(e(5'd3, 5'd0, 5'd3, 6'b001100, 3'd0, 5'd0, 3'd0, 2'd0, 1'b0), 32'h208);
    send(32'h00100093, 32'h200);
    send(32'h00200113, 32'h204);
    check_bit("bp_in_ready_low", in_ready, 1'b0);
    head = cur_beat();
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;
    repeat (3) begin
      cyc(acc);
      check_bit("bp_no_accept", acc, 1'b0);
      check_beat("bp_head_stable", cur_beat(), head);
    end
    out_ready = 1'b1;
    send(32'h00300193, 32'h208);
    drain(4);
    check_int("bp_drained", exp_q.size(), 0);

    // Flush with full buffer and pending slot
    out_ready = 1'b0;
    send(32'h0000A283, 32'h300);
    send(32'h00228333, 32'h304);
    check_bit("fl_pre_in_ready", in_ready, 1'b0);
    check_bit("fl_pre_out_valid", out_valid, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h40000033; in_pc = 32'h308;
    cyc(acc);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_bit("fl_out_valid", out_valid, 1'b0);
    check_bit("fl_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_exp(e_add, 32'h310);
    send(32'h00228333, 32'h310);
    drain(4);
    check_int("fl_no_bubble_drained", exp_q.size(), 0);

    // Asynchronous reset while a bundle is waiting
    out_ready = 1'b0;
    send(32'h00228333, 32'h400);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("arst_out_valid", out_valid, 1'b0);
    check_beat("arst_bundle_zero", cur_beat(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drain(3);
    check_int("arst_no_beat", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
